// File: rtl/core_array_collector.sv
// Collects one output chunk per MAC core, then streams the chunks out and re-arms the cores.
// Latency: the last core's done sampled at edge t gives out_valid high from edge t; one beat per handshake.
// Backpressure: out_ready low holds out_data/out_idx/out_last; cores reporting during drain/clear set overrun.
module core_array_collector #(
   parameter int WIDTH      = 16,
   parameter int CHUNK_SIZE = 4,
   parameter int NUM_CORES  = 4,
   parameter int OUT_ORDER  = 0,
   localparam int CW = WIDTH * CHUNK_SIZE,
   localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [NUM_CORES-1:0]    core_done,
   input  logic [CW*NUM_CORES-1:0] core_out,
   output logic [CW-1:0]           out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [IW-1:0]           out_idx,
   output logic                    reset_acc,
   output logic                    busy,
   output logic                    overrun
);

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DRAIN   = 2'd1,
      CLEAR   = 2'd2
   } state_t;

   localparam logic [IW-1:0] FIRST_IDX = (OUT_ORDER != 0) ? IW'(NUM_CORES - 1) : IW'(0);
   localparam logic [IW-1:0] LAST_IDX  = (OUT_ORDER != 0) ? IW'(0) : IW'(NUM_CORES - 1);

   state_t                 state, state_nxt;
   logic [CW-1:0]          chunk_reg  [NUM_CORES];
   logic [CW-1:0]          chunk_next [NUM_CORES];
   logic [NUM_CORES-1:0]   done_mask;
   logic [NUM_CORES-1:0]   capture;
   logic [NUM_CORES-1:0]   mask_next;
   logic                   all_done;
   logic                   hs;
   logic [IW-1:0]          next_idx;
   logic [IW-1:0]          rd_idx;
   logic [CW-1:0]          rd_data;

   // Capture qualification: only first done per core, only while collecting and enabled.
   always_comb begin
      capture   = '0;
      if (state == COLLECT && en)
         capture = core_done & ~done_mask;
      mask_next = done_mask | capture;
      all_done  = &mask_next;
      hs        = out_valid & out_ready;
      next_idx  = (OUT_ORDER != 0) ? (out_idx - IW'(1)) : (out_idx + IW'(1));
   end

   // Chunk values as they will be after this edge, so the first beat can see a same-edge capture.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++)
         chunk_next[i] = capture[i] ? core_out[i*CW +: CW] : chunk_reg[i];
   end

   // Read mux: first index on drain entry, otherwise the index about to be presented.
   always_comb begin
      rd_idx  = (state == COLLECT) ? FIRST_IDX : next_idx;
      rd_data = '0;
      for (int i = 0; i < NUM_CORES; i++)
         if (IW'(i) == rd_idx)
            rd_data = chunk_next[i];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= COLLECT;
      else
         state <= state_nxt;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      reset_acc = 1'b0;
      case (state)
         COLLECT: begin
            if (all_done)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (hs && out_last)
               state_nxt = CLEAR;
         end
         CLEAR: begin
            busy      = 1'b1;
            reset_acc = 1'b1;
            state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   // Per-core chunk storage; contents are don't-care until the matching mask bit is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CORES; i++)
         if (capture[i])
            chunk_reg[i] <= core_out[i*CW +: CW];
   end

   // Mask, output beat registers and the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_mask <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
         overrun   <= 1'b0;
      end else begin
         if (state != COLLECT && |core_done)
            overrun <= 1'b1;
         case (state)
            COLLECT: begin
               done_mask <= mask_next;
               if (all_done) begin
                  out_valid <= 1'b1;
                  out_idx   <= FIRST_IDX;
                  out_data  <= rd_data;
                  out_last  <= (NUM_CORES == 1);
               end
            end
            DRAIN: begin
               if (hs) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done_mask <= '0;
                  end else begin
                     out_idx  <= next_idx;
                     out_data <= rd_data;
                     out_last <= (next_idx == LAST_IDX);
                  end
               end
            end
            default: begin
               done_mask <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_array_collector.sv
// Directed bench for core_array_collector: forward, reversed and single-core instances.
// Outputs are sampled on the falling edge; inputs change right after sampling.
// Each bench wait is a fixed cycle count, so the run always ends on its own.
module tb_core_array_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, en, out_ready;
   logic [3:0]   core_done;
   logic [255:0] core_out;
   logic [63:0]  out_data;
   logic         out_valid, out_last, reset_acc, busy, overrun;
   logic [1:0]   out_idx;

   logic [3:0]   r_done;
   logic [255:0] r_out;
   logic         r_ready;
   logic [63:0]  r_data;
   logic         r_valid, r_last, r_racc, r_busy, r_ovr;
   logic [1:0]   r_idx;

   logic [0:0]   o_done;
   logic [63:0]  o_out;
   logic         o_ready;
   logic [63:0]  o_data;
   logic         o_valid, o_last, o_racc, o_busy, o_ovr;
   logic [0:0]   o_idx;

   core_array_collector #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(4), .OUT_ORDER(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .core_done(core_done), .core_out(core_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_idx(out_idx), .reset_acc(reset_acc), .busy(busy), .overrun(overrun)
   );

   core_array_collector #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(4), .OUT_ORDER(1)) u_rev (
      .clk(clk), .rst_n(rst_n), .en(1'b1), .core_done(r_done), .core_out(r_out),
      .out_data(r_data), .out_valid(r_valid), .out_ready(r_ready), .out_last(r_last),
      .out_idx(r_idx), .reset_acc(r_racc), .busy(r_busy), .overrun(r_ovr)
   );

   core_array_collector #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(1), .OUT_ORDER(0)) u_one (
      .clk(clk), .rst_n(rst_n), .en(1'b1), .core_done(o_done), .core_out(o_out),
      .out_data(o_data), .out_valid(o_valid), .out_ready(o_ready), .out_last(o_last),
      .out_idx(o_idx), .reset_acc(o_racc), .busy(o_busy), .overrun(o_ovr)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] base(input int i);
      return {4{16'(i + 1)}};
   endfunction

   function automatic logic [63:0] pat(input int i, input int t);
      return {16'hC000 | 16'(i), 16'(t), 16'hBEEF, 16'(i * 16 + t)};
   endfunction

   task automatic set_base();
      for (int i = 0; i < 4; i++) core_out[i*64 +: 64] = base(i);
   endtask

   task automatic set_pat(input int t);
      for (int i = 0; i < 4; i++) core_out[i*64 +: 64] = pat(i, t);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; out_ready = 1'b0; core_done = '0;
      r_done = '0; r_ready = 1'b0; o_done = '0; o_ready = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   int te [4] = '{3, 9, 0, 5};
   int rs [7] = '{1, 0, 0, 1, 0, 1, 1};
   int beats;

   initial begin
      core_out = '0; r_out = '0; o_out = '0;
      @(negedge clk);
      do_reset();
      // Reset state
      chk("rst valid", 64'(out_valid), 64'd0);
      chk("rst last",  64'(out_last),  64'd0);
      chk("rst idx",   64'(out_idx),   64'd0);
      chk("rst racc",  64'(reset_acc), 64'd0);
      chk("rst busy",  64'(busy),      64'd0);
      chk("rst ovr",   64'(overrun),   64'd0);
      chk("rst data",  out_data,       64'd0);

      // 1: simultaneous done, ready held high
      en = 1'b1; out_ready = 1'b1; set_base(); core_done = 4'hF;
      cyc();
      core_done = '0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t1 valid%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("t1 idx%0d", k),   64'(out_idx),   64'(k));
         chk($sformatf("t1 data%0d", k),  out_data,       base(k));
         chk($sformatf("t1 last%0d", k),  64'(out_last),  64'(k == 3));
         chk($sformatf("t1 busy%0d", k),  64'(busy),      64'd1);
         cyc();
      end
      chk("t1 clr valid", 64'(out_valid), 64'd0);
      chk("t1 clr racc",  64'(reset_acc), 64'd1);
      chk("t1 clr busy",  64'(busy),      64'd1);
      cyc();
      chk("t1 idle racc", 64'(reset_acc), 64'd0);
      chk("t1 idle busy", 64'(busy),      64'd0);

      // 2: staggered done, core_out changing every cycle
      do_reset();
      en = 1'b1; out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         set_pat(t);
         case (t)
            0:       core_done = 4'b0100;
            3:       core_done = 4'b0001;
            5:       core_done = 4'b1000;
            9:       core_done = 4'b0010;
            default: core_done = 4'b0000;
         endcase
         cyc();
         if (t < 9) chk($sformatf("t2 early valid t%0d", t), 64'(out_valid), 64'd0);
      end
      core_done = '0; set_pat(20);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2 valid%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("t2 idx%0d", k),   64'(out_idx),   64'(k));
         chk($sformatf("t2 data%0d", k),  out_data,       pat(k, te[k]));
         cyc();
      end
      cyc();

      // 3: backpressure pattern
      do_reset();
      en = 1'b1; out_ready = 1'b0; set_base(); core_done = 4'hF;
      cyc();
      core_done = '0;
      beats = 0;
      for (int j = 0; j < 7; j++) begin
         chk($sformatf("t3 valid%0d", j), 64'(out_valid), 64'(beats < 4));
         if (beats < 4) begin
            chk($sformatf("t3 idx%0d", j),  64'(out_idx),  64'(beats));
            chk($sformatf("t3 data%0d", j), out_data,      base(beats));
            chk($sformatf("t3 last%0d", j), 64'(out_last), 64'(beats == 3));
         end
         out_ready = (rs[j] != 0);
         if (out_valid && out_ready) beats++;
         cyc();
      end
      chk("t3 beats",     64'(beats),     64'd4);
      chk("t3 end valid", 64'(out_valid), 64'd0);
      chk("t3 end racc",  64'(reset_acc), 64'd1);
      cyc();

      // 4: done re-pulsed during drain
      do_reset();
      en = 1'b1; out_ready = 1'b1; set_base(); core_done = 4'hF;
      cyc();
      chk("t4 idx0",  64'(out_idx), 64'd0);
      chk("t4 data0", out_data,     base(0));
      core_done = 4'b0010; set_pat(99);
      cyc();
      core_done = '0;
      chk("t4 ovr set", 64'(overrun), 64'd1);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("t4 idx%0d", k),  64'(out_idx), 64'(k));
         chk($sformatf("t4 data%0d", k), out_data,     base(k));
         cyc();
      end
      chk("t4 clr racc", 64'(reset_acc), 64'd1);
      cyc();
      set_pat(50); core_done = 4'b1101;
      cyc();
      core_done = '0;
      chk("t4 mask empty valid", 64'(out_valid), 64'd0);
      chk("t4 mask empty busy",  64'(busy),      64'd0);
      core_done = 4'b0010;
      cyc();
      core_done = '0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4 g2 valid%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("t4 g2 data%0d", k),  out_data,       pat(k, 50));
         cyc();
      end
      cyc();
      chk("t4 ovr sticky", 64'(overrun), 64'd1);

      // 5: done ignored while en is low
      do_reset();
      en = 1'b0; out_ready = 1'b1; set_pat(1); core_done = 4'b0001;
      cyc();
      en = 1'b1; set_pat(2); core_done = 4'b1110;
      cyc();
      chk("t5 no drain", 64'(out_valid), 64'd0);
      set_pat(3); core_done = 4'b0001;
      cyc();
      core_done = '0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t5 valid%0d", k), 64'(out_valid), 64'd1);
         chk($sformatf("t5 data%0d", k),  out_data,       (k == 0) ? pat(0, 3) : pat(k, 2));
         cyc();
      end
      cyc();
      chk("t5 no ovr", 64'(overrun), 64'd0);

      // 6a: reversed drain order
      do_reset();
      r_ready = 1'b1;
      for (int i = 0; i < 4; i++) r_out[i*64 +: 64] = base(i);
      r_done = 4'hF;
      cyc();
      r_done = '0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t6r valid%0d", k), 64'(r_valid), 64'd1);
         chk($sformatf("t6r idx%0d", k),   64'(r_idx),   64'(3 - k));
         chk($sformatf("t6r data%0d", k),  r_data,       base(3 - k));
         chk($sformatf("t6r last%0d", k),  64'(r_last),  64'(k == 3));
         cyc();
      end
      chk("t6r racc", 64'(r_racc), 64'd1);
      cyc();

      // 6b: single core
      o_out = 64'hDEAD_BEEF_0123_4567; o_ready = 1'b0; o_done = 1'b1;
      cyc();
      o_done = '0;
      chk("t6s valid", 64'(o_valid), 64'd1);
      chk("t6s last",  64'(o_last),  64'd1);
      chk("t6s idx",   64'(o_idx),   64'd0);
      chk("t6s data",  o_data,       64'hDEAD_BEEF_0123_4567);
      cyc();
      chk("t6s hold valid", 64'(o_valid), 64'd1);
      o_ready = 1'b1;
      cyc();
      chk("t6s done valid", 64'(o_valid), 64'd0);
      chk("t6s racc",       64'(o_racc),  64'd1);
      cyc();
      chk("t6s idle busy",  64'(o_busy),  64'd0);

      // 6c: reset asserted mid-drain
      do_reset();
      en = 1'b1; out_ready = 1'b0; set_base(); core_done = 4'hF;
      cyc();
      core_done = '0;
      chk("t6c in drain", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      cyc();
      chk("t6c valid", 64'(out_valid), 64'd0);
      chk("t6c last",  64'(out_last),  64'd0);
      chk("t6c idx",   64'(out_idx),   64'd0);
      chk("t6c data",  out_data,       64'd0);
      chk("t6c busy",  64'(busy),      64'd0);
      chk("t6c racc",  64'(reset_acc), 64'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         cyc();
         chk($sformatf("t6c quiet valid%0d", j), 64'(out_valid), 64'd0);
         chk($sformatf("t6c quiet busy%0d", j),  64'(busy),      64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
